// File: rtl/upload_unpacker_if.sv
// Byte-stream input, raw payload output and per-frame status of the upload unpacker.
// master is the unpacker side; slave is the receiver/consumer side.
interface upload_unpacker_if;
   logic [7:0] packed_upload_data;
   logic       packed_upload_valid;
   logic       packed_upload_ready;
   logic       raw_upload_req;
   logic [7:0] raw_upload_data;
   logic [7:0] raw_upload_source;
   logic       raw_upload_valid;
   logic       raw_upload_ready;
   logic       frame_ok;
   logic       frame_error;

   modport master (
      input  packed_upload_data, packed_upload_valid, raw_upload_ready,
      output packed_upload_ready, raw_upload_req, raw_upload_data,
             raw_upload_source, raw_upload_valid, frame_ok, frame_error
   );

   modport slave (
      output packed_upload_data, packed_upload_valid, raw_upload_ready,
      input  packed_upload_ready, raw_upload_req, raw_upload_data,
             raw_upload_source, raw_upload_valid, frame_ok, frame_error
   );
endinterface

// File: rtl/upload_unpacker.sv
// Unpacks AA 44 SRC LEN_H LEN_L payload CSUM frames and streams the payload out unbuffered.
//
// state     | meaning
// S_HUNT    | waiting for first header byte AA
// S_HDR2    | AA seen, waiting for 44
// S_SRC     | next byte is the source ID
// S_LEN_H   | next byte is length high
// S_LEN_L   | next byte is length low
// S_PAYLOAD | forwarding payload bytes to the raw side
// S_CSUM    | next byte is the checksum
module upload_unpacker #(
   parameter int MAX_LEN        = 1024,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic               clk,
   input  logic               rst,
   upload_unpacker_if.master  bus
);
   localparam int            TW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYCLES);
   localparam logic [16:0]   LEN_LIM = 17'(MAX_LEN);

   typedef enum logic [2:0] {
      S_HUNT, S_HDR2, S_SRC, S_LEN_H, S_LEN_L, S_PAYLOAD, S_CSUM
   } state_t;

   state_t        state;
   logic [7:0]    len_h;
   logic [7:0]    csum;
   logic [7:0]    src_q;
   logic [7:0]    out_data;
   logic [15:0]   remaining;
   logic          out_valid;
   logic          out_last;
   logic          req_q;
   logic          ok_q;
   logic          err_q;
   logic [TW-1:0] tmo_cnt;

   logic          ready_c;
   logic          accept;
   logic          raw_hs;
   logic          tmo_hit;
   logic [7:0]    in_byte;
   logic [15:0]   len_full;

   assign in_byte  = bus.packed_upload_data;
   assign len_full = {len_h, in_byte};
   assign ready_c  = rst ? 1'b0 :
                     (state == S_PAYLOAD) ? (!out_valid || bus.raw_upload_ready) : 1'b1;
   assign accept   = bus.packed_upload_valid && ready_c;
   assign raw_hs   = out_valid && bus.raw_upload_ready;
   assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (state != S_HUNT) && !accept && (tmo_cnt == TMO_LIM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_HUNT;
         len_h     <= '0;
         csum      <= '0;
         src_q     <= '0;
         out_data  <= '0;
         remaining <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         req_q     <= 1'b0;
         ok_q      <= 1'b0;
         err_q     <= 1'b0;
         tmo_cnt   <= '0;
      end else begin
         ok_q  <= 1'b0;
         err_q <= 1'b0;

         // req stays up until the final payload byte has left the output register
         if (raw_hs) begin
            out_valid <= 1'b0;
            if (out_last) begin
               req_q    <= 1'b0;
               out_last <= 1'b0;
            end
         end

         if (accept || state == S_HUNT)
            tmo_cnt <= '0;
         else if (tmo_cnt != TMO_LIM)
            tmo_cnt <= tmo_cnt + 1'b1;

         if (tmo_hit) begin
            err_q     <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            req_q     <= 1'b0;
            tmo_cnt   <= '0;
            state     <= S_HUNT;
         end else if (accept) begin
            case (state)
               S_HUNT:
                  if (in_byte == 8'hAA) state <= S_HDR2;
               S_HDR2:
                  if (in_byte == 8'h44)      state <= S_SRC;
                  else if (in_byte != 8'hAA) state <= S_HUNT;
               S_SRC: begin
                  src_q <= in_byte;
                  csum  <= in_byte;
                  state <= S_LEN_H;
               end
               S_LEN_H: begin
                  len_h <= in_byte;
                  csum  <= csum + in_byte;
                  state <= S_LEN_L;
               end
               S_LEN_L: begin
                  csum      <= csum + in_byte;
                  remaining <= len_full;
                  if ({1'b0, len_full} > LEN_LIM) begin
                     err_q <= 1'b1;
                     state <= S_HUNT;
                  end else if (len_full == 16'd0) begin
                     state <= S_CSUM;
                  end else begin
                     req_q <= 1'b1;
                     state <= S_PAYLOAD;
                  end
               end
               S_PAYLOAD: begin
                  csum      <= csum + in_byte;
                  out_data  <= in_byte;
                  out_valid <= 1'b1;
                  remaining <= remaining - 1'b1;
                  if (remaining == 16'd1) begin
                     out_last <= 1'b1;
                     state    <= S_CSUM;
                  end
               end
               S_CSUM: begin
                  if (in_byte == csum) ok_q  <= 1'b1;
                  else                 err_q <= 1'b1;
                  state <= S_HUNT;
               end
               default: state <= S_HUNT;
            endcase
         end
      end
   end

   assign bus.packed_upload_ready = ready_c;
   assign bus.raw_upload_req      = req_q;
   assign bus.raw_upload_data     = out_data;
   assign bus.raw_upload_source   = src_q;
   assign bus.raw_upload_valid    = out_valid;
   assign bus.frame_ok            = ok_q;
   assign bus.frame_error         = err_q;
endmodule

// File: tb/tb_upload_unpacker.sv
// Randomized frame-level bench for upload_unpacker: frames are built from source/payload,
// and delivered bytes and verdicts are compared against what each frame should produce.
module tb_upload_unpacker;
   localparam int TMO  = 64;
   localparam int MAXL = 1024;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   upload_unpacker_if bus();

   upload_unpacker #(.MAX_LEN(MAXL), .TIMEOUT_CYCLES(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] got_q[$];
   int         ok_cnt = 0;
   int         err_cnt = 0;
   bit         saw_stall = 0;
   bit         saw_req = 0;
   logic [7:0] exp_src = 8'h00;
   int         rr_mode = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // frame model: header, source, length, payload, modulo-256 sum of everything after 44
   function automatic bq_t build_frame(input logic [7:0] src, input bq_t pl, input bit corrupt);
      bq_t        f;
      int         sum;
      logic [15:0] len;
      len = 16'(pl.size());
      sum = src + len[15:8] + len[7:0];
      foreach (pl[i]) sum += pl[i];
      f = {8'hAA, 8'h44, src, len[15:8], len[7:0]};
      foreach (pl[i]) f.push_back(pl[i]);
      f.push_back(8'((sum % 256) + (corrupt ? 1 : 0)));
      return f;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.raw_upload_valid && bus.raw_upload_ready) got_q.push_back(bus.raw_upload_data);
         if (bus.frame_ok)    ok_cnt++;
         if (bus.frame_error) err_cnt++;
         if (bus.frame_ok || bus.frame_error)
            check("ok_err_exclusive", {31'd0, bus.frame_ok & bus.frame_error}, 32'd0);
         if (bus.raw_upload_valid) begin
            check("req_with_valid", {31'd0, bus.raw_upload_req}, 32'd1);
            check("source", {24'd0, bus.raw_upload_source}, {24'd0, exp_src});
         end
         if (bus.packed_upload_valid && !bus.packed_upload_ready) saw_stall = 1;
         if (bus.raw_upload_req) saw_req = 1;
      end
   end

   initial begin
      bus.raw_upload_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rr_mode)
            0:       bus.raw_upload_ready = 1'b1;
            1:       bus.raw_upload_ready = ~bus.raw_upload_ready;
            2:       bus.raw_upload_ready = ($urandom_range(0, 3) != 0);
            default: bus.raw_upload_ready = 1'b0;
         endcase
      end
   end

   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int t;
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin
         bus.packed_upload_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      bus.packed_upload_valid = 1'b1;
      bus.packed_upload_data  = b;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!bus.packed_upload_ready && t < 200);
      if (!bus.packed_upload_ready) check("ready_wait", {31'd0, bus.packed_upload_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus.packed_upload_valid = 1'b0;
   endtask

   task automatic send_list(input bq_t q, input int max_gap);
      foreach (q[i]) send_byte(q[i], max_gap);
   endtask

   task automatic run_frame(input string tag, input logic [7:0] src, input bq_t pl,
                            input bit corrupt, input int max_gap);
      int ok0, err0;
      got_q.delete();
      ok0 = ok_cnt;
      err0 = err_cnt;
      exp_src = src;
      send_list(build_frame(src, pl, corrupt), max_gap);
      repeat (40) @(negedge clk);
      check({tag, "_count"}, got_q.size(), pl.size());
      foreach (pl[i])
         if (i < got_q.size()) check({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, pl[i]});
      check({tag, "_ok"},  ok_cnt - ok0,  corrupt ? 0 : 1);
      check({tag, "_err"}, err_cnt - err0, corrupt ? 1 : 0);
      check({tag, "_req_end"},   {31'd0, bus.raw_upload_req},   32'd0);
      check({tag, "_valid_end"}, {31'd0, bus.raw_upload_valid}, 32'd0);
   endtask

   bq_t nom;
   bq_t pl;
   bq_t raw;

   initial begin
      int ok0, err0, c;
      bus.packed_upload_valid = 1'b0;
      bus.packed_upload_data  = 8'h00;
      nom = {8'hA1, 8'hA2, 8'hA3};
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, bus.packed_upload_ready}, 32'd0);
      check("rst_valid", {31'd0, bus.raw_upload_valid}, 32'd0);
      check("rst_req",   {31'd0, bus.raw_upload_req}, 32'd0);
      check("rst_src",   {24'd0, bus.raw_upload_source}, 32'd0);
      check("rst_ok",    {31'd0, bus.frame_ok | bus.frame_error}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("hunt_ready", {31'd0, bus.packed_upload_ready}, 32'd1);

      rr_mode = 0;
      run_frame("nominal", 8'h01, nom, 1'b0, 0);
      check("nominal_csum_byte", {24'd0, build_frame(8'h01, nom, 1'b0)[8]}, 32'h0000_00EA);
      run_frame("bad_csum", 8'h01, nom, 1'b1, 0);

      rr_mode = 1;
      saw_stall = 0;
      run_frame("backpressure", 8'h01, nom, 1'b0, 0);
      check("bp_stall_seen", {31'd0, saw_stall}, 32'd1);

      // resync through a stray byte and a repeated AA, zero-length frame
      rr_mode = 0;
      got_q.delete();
      saw_req = 0;
      ok0 = ok_cnt; err0 = err_cnt;
      raw = {8'h55, 8'hAA, 8'hAA, 8'h44, 8'h07, 8'h00, 8'h00, 8'h07};
      send_list(raw, 0);
      repeat (4) @(negedge clk);
      check("zero_len_ok", ok_cnt - ok0, 1);
      check("zero_len_err", err_cnt - err0, 0);
      check("zero_len_no_data", got_q.size(), 0);
      check("zero_len_no_req", {31'd0, saw_req}, 32'd0);

      ok0 = ok_cnt; err0 = err_cnt;
      raw = {8'hAA, 8'h44, 8'h09, 8'h04, 8'h01};
      send_list(raw, 0);
      repeat (2) @(negedge clk);
      check("overlen_err", err_cnt - err0, 1);
      check("overlen_ok", ok_cnt - ok0, 0);
      check("overlen_req", {31'd0, bus.raw_upload_req}, 32'd0);
      run_frame("after_overlen", 8'h22, nom, 1'b0, 1);

      pl.delete();
      repeat (MAXL) pl.push_back(8'($urandom));
      rr_mode = 2;
      run_frame("max_len", 8'h5C, pl, 1'b0, 1);

      for (int k = 0; k < 20; k++) begin
         pl.delete();
         repeat ($urandom_range(1, 12)) pl.push_back(8'($urandom));
         rr_mode = int'($urandom_range(0, 2));
         run_frame("random", 8'($urandom), pl, ($urandom_range(0, 3) == 0), 2);
      end

      // stall mid-payload until the inter-byte timeout fires
      rr_mode = 0;
      got_q.delete();
      exp_src = 8'h01;
      err0 = err_cnt;
      raw = {8'hAA, 8'h44, 8'h01, 8'h00, 8'h05, 8'hA1};
      send_list(raw, 0);
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!bus.frame_error && c < 3 * TMO);
      check("tmo_pulse", {31'd0, bus.frame_error}, 32'd1);
      check("tmo_latency_window", {31'd0, (c >= TMO && c <= TMO + 3)}, 32'd1);
      check("tmo_req_drop", {31'd0, bus.raw_upload_req}, 32'd0);
      check("tmo_valid_drop", {31'd0, bus.raw_upload_valid}, 32'd0);
      check("tmo_delivered", got_q.size(), 1);
      @(negedge clk);
      check("tmo_single_pulse", err_cnt - err0, 1);
      run_frame("after_tmo", 8'h33, nom, 1'b0, 0);

      // reset while a payload byte is held on the raw side
      rr_mode = 3;
      exp_src = 8'h02;
      raw = {8'hAA, 8'h44, 8'h02, 8'h00, 8'h05, 8'hA1};
      send_list(raw, 0);
      @(negedge clk);
      check("pre_rst_valid", {31'd0, bus.raw_upload_valid}, 32'd1);
      ok0 = ok_cnt; err0 = err_cnt;
      rst = 1'b1;
      #1;
      check("midrst_ready", {31'd0, bus.packed_upload_ready}, 32'd0);
      check("midrst_valid", {31'd0, bus.raw_upload_valid}, 32'd0);
      check("midrst_req",   {31'd0, bus.raw_upload_req}, 32'd0);
      check("midrst_src",   {24'd0, bus.raw_upload_source}, 32'd0);
      check("midrst_data",  {24'd0, bus.raw_upload_data}, 32'd0);
      check("midrst_status", {31'd0, bus.frame_ok | bus.frame_error}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rr_mode = 0;
      @(negedge clk);
      check("midrst_no_pulse", (ok_cnt - ok0) + (err_cnt - err0), 0);
      run_frame("after_rst", 8'h01, nom, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish by 2000000", $time);
      $fatal(1);
   end
endmodule
